// File: rtl/fetch_rsp_ibuffer.sv
// fetch_rsp_ibuffer: instruction buffer fed by the icache fetch response.
// Extracts up to NUM_FETCH instructions from a hit cache block into per-warp
// FIFOs for decode, raises a one-cycle replay on a miss, and tracks per-warp
// in-flight fetch credit so the fetch unit never over-commits a FIFO.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_fire_i, req_wid_i       fetch request issued (reserves NUM_FETCH slots)
//   fetch_ok_o[NUM_WARP]        warp has room for another full fetch
//   rsp_*_i                     icache response (valid/addr/data/mask/wid/status)
//   flush_valid_i, flush_wid_i  drop one warp's buffered and in-flight state
//   replay_valid_o/wid_o/pc_o   registered miss replay pulse
//   ib_valid_o/ib_ready_i       per-warp FIFO head handshake
//   ib_inst_o, ib_pc_o          per-warp head instruction / PC
//   ovf_err_o                   sticky FIFO overflow
//
// Optional feature: define IBUF_PERF_EN to add perf_hit_o / perf_miss_o
// response counters.
module fetch_rsp_ibuffer #(
   parameter int unsigned WARP_DEPTH  = 2,
   parameter int unsigned NUM_FETCH   = 2,
   parameter int unsigned BLOCK_WORDS = 8,
   parameter int unsigned IB_DEPTH    = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            req_fire_i,
   input  logic [WARP_DEPTH-1:0]           req_wid_i,
   output logic [(1<<WARP_DEPTH)-1:0]      fetch_ok_o,
   input  logic                            rsp_valid_i,
   input  logic [31:0]                     rsp_addr_i,
   input  logic [BLOCK_WORDS*32-1:0]       rsp_data_i,
   input  logic [NUM_FETCH-1:0]            rsp_mask_i,
   input  logic [WARP_DEPTH-1:0]           rsp_wid_i,
   input  logic                            rsp_status_i,
   input  logic                            flush_valid_i,
   input  logic [WARP_DEPTH-1:0]           flush_wid_i,
   output logic                            replay_valid_o,
   output logic [WARP_DEPTH-1:0]           replay_wid_o,
   output logic [31:0]                     replay_pc_o,
   output logic [(1<<WARP_DEPTH)-1:0]      ib_valid_o,
   input  logic [(1<<WARP_DEPTH)-1:0]      ib_ready_i,
   output logic [(1<<WARP_DEPTH)*32-1:0]   ib_inst_o,
   output logic [(1<<WARP_DEPTH)*32-1:0]   ib_pc_o,
`ifdef IBUF_PERF_EN
   output logic [31:0]                     perf_hit_o,
   output logic [31:0]                     perf_miss_o,
`endif
   output logic                            ovf_err_o
);

   localparam int unsigned NUM_WARP = 1 << WARP_DEPTH;
   localparam int unsigned WOFF     = $clog2(BLOCK_WORDS);
   localparam int unsigned PTR_W    = $clog2(IB_DEPTH);
   localparam int unsigned CNT_W    = PTR_W + 1;
   localparam int unsigned ACC_W    = CNT_W + 1;
   localparam int unsigned RES_W    = CNT_W + 2;

   // Architectural state
   logic [PTR_W-1:0] rd_ptr   [NUM_WARP];
   logic [PTR_W-1:0] wr_ptr   [NUM_WARP];
   logic [CNT_W-1:0] count    [NUM_WARP];
   logic [RES_W-1:0] reserved [NUM_WARP];
   logic [31:0]      inst_mem [NUM_WARP][IB_DEPTH];
   logic [31:0]      pc_mem   [NUM_WARP][IB_DEPTH];

   // Next-state / decode
   logic [WOFF-1:0]      idx;
   logic [NUM_FETCH-1:0] slot_ok;
   logic [ACC_W-1:0]     rank     [NUM_FETCH];
   logic [WOFF-1:0]      widx     [NUM_FETCH];
   logic                 wr_en    [NUM_FETCH];
   logic [PTR_W-1:0]     wr_pos   [NUM_FETCH];
   logic [ACC_W-1:0]     nvalid;
   logic                 rsp_take;
   logic                 hit_take;
   logic                 ovf_set;
   logic [ACC_W-1:0]     space    [NUM_WARP];
   logic [CNT_W-1:0]     count_nx [NUM_WARP];
   logic [PTR_W-1:0]     rd_nx    [NUM_WARP];
   logic [PTR_W-1:0]     wr_nx    [NUM_WARP];
   logic [RES_W-1:0]     res_nx   [NUM_WARP];

   // Slot selection: which block words are valid and their compacted order
   always_comb begin : slot_decode
      idx    = rsp_addr_i[WOFF+1:2];
      nvalid = '0;
      for (int i = 0; i < int'(NUM_FETCH); i++) begin
         slot_ok[i] = rsp_mask_i[i] && ((int'(idx) + i) < int'(BLOCK_WORDS));
         rank[i]    = nvalid;
         widx[i]    = WOFF'(int'(idx) + i);
         nvalid     = nvalid + ACC_W'(slot_ok[i]);
      end
   end

   // A response to the warp being flushed this cycle is discarded entirely
   assign rsp_take = rsp_valid_i && !(flush_valid_i && (flush_wid_i == rsp_wid_i));
   assign hit_take = rsp_take && !rsp_status_i;

   // Per-warp pointer, occupancy and credit update
   always_comb begin : warp_next
      for (int w = 0; w < int'(NUM_WARP); w++) begin
         logic             flush_w;
         logic             pop_w;
         logic             inc_w;
         logic             dec_w;
         logic [ACC_W-1:0] push_w;
         flush_w  = flush_valid_i && (flush_wid_i == WARP_DEPTH'(w));
         pop_w    = (count[w] != '0) && ib_ready_i[w];
         inc_w    = req_fire_i && (req_wid_i == WARP_DEPTH'(w)) && !flush_w;
         dec_w    = rsp_valid_i && (rsp_wid_i == WARP_DEPTH'(w));
         // A same-cycle pop frees a slot for this cycle's push
         space[w] = ACC_W'(IB_DEPTH) - ACC_W'(count[w]) + ACC_W'(pop_w);
         push_w   = '0;
         if (hit_take && (rsp_wid_i == WARP_DEPTH'(w)))
            push_w = (nvalid < space[w]) ? nvalid : space[w];

         count_nx[w] = CNT_W'(ACC_W'(count[w]) + push_w - ACC_W'(pop_w));
         rd_nx[w]    = rd_ptr[w] + PTR_W'(pop_w);
         wr_nx[w]    = wr_ptr[w] + PTR_W'(push_w);

         res_nx[w] = reserved[w];
         if (inc_w && !dec_w)
            res_nx[w] = reserved[w] + RES_W'(NUM_FETCH);
         else if (dec_w && !inc_w)
            res_nx[w] = (reserved[w] >= RES_W'(NUM_FETCH)) ? reserved[w] - RES_W'(NUM_FETCH) : '0;

         if (flush_w) begin
            count_nx[w] = '0;
            rd_nx[w]    = '0;
            wr_nx[w]    = '0;
            res_nx[w]   = '0;
         end
      end
   end

   // Storage writes: slots beyond free space are dropped, never written
   always_comb begin : write_decode
      ovf_set = hit_take && (nvalid > space[rsp_wid_i]);
      for (int i = 0; i < int'(NUM_FETCH); i++) begin
         wr_en[i]  = hit_take && slot_ok[i] && (rank[i] < space[rsp_wid_i]);
         wr_pos[i] = wr_ptr[rsp_wid_i] + PTR_W'(rank[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) begin
         for (int w = 0; w < int'(NUM_WARP); w++) begin
            rd_ptr[w]   <= '0;
            wr_ptr[w]   <= '0;
            count[w]    <= '0;
            reserved[w] <= '0;
         end
         ovf_err_o      <= 1'b0;
         replay_valid_o <= 1'b0;
         replay_wid_o   <= '0;
         replay_pc_o    <= '0;
      end else begin
         for (int w = 0; w < int'(NUM_WARP); w++) begin
            rd_ptr[w]   <= rd_nx[w];
            wr_ptr[w]   <= wr_nx[w];
            count[w]    <= count_nx[w];
            reserved[w] <= res_nx[w];
         end
         if (ovf_set)
            ovf_err_o <= 1'b1;
         replay_valid_o <= rsp_take && rsp_status_i;
         if (rsp_take && rsp_status_i) begin
            replay_wid_o <= rsp_wid_i;
            replay_pc_o  <= rsp_addr_i;
         end
      end
   end

   // FIFO payload storage (no reset needed: guarded by count)
   always_ff @(posedge clk) begin : fifo_mem
      for (int i = 0; i < int'(NUM_FETCH); i++) begin
         if (wr_en[i]) begin
            inst_mem[rsp_wid_i][wr_pos[i]] <= rsp_data_i[int'(widx[i])*32 +: 32];
            pc_mem[rsp_wid_i][wr_pos[i]]   <= rsp_addr_i + 32'(4 * i);
         end
      end
   end

   // Head view and credit status, decoded from registers only
   always_comb begin : head_out
      for (int w = 0; w < int'(NUM_WARP); w++) begin
         ib_valid_o[w]        = (count[w] != '0);
         ib_inst_o[w*32 +: 32] = inst_mem[w][rd_ptr[w]];
         ib_pc_o[w*32 +: 32]   = pc_mem[w][rd_ptr[w]];
         fetch_ok_o[w]        = (int'(count[w]) + int'(reserved[w]) + int'(NUM_FETCH)) <= int'(IB_DEPTH);
      end
   end

`ifdef IBUF_PERF_EN
   // Hit/miss response counters; flushed responses are not counted
   always_ff @(posedge clk or negedge rst_n) begin : perf_cnt
      if (!rst_n) begin
         perf_hit_o  <= '0;
         perf_miss_o <= '0;
      end else if (rsp_take) begin
         if (rsp_status_i)
            perf_miss_o <= perf_miss_o + 32'd1;
         else
            perf_hit_o  <= perf_hit_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_rsp_ibuffer.sv
// Directed table-driven bench for fetch_rsp_ibuffer (default parameters:
// 4 warps, 2 fetch slots, 8-word blocks, 4-entry FIFOs).
module tb_fetch_rsp_ibuffer;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_fire;
   logic [1:0]    req_wid;
   logic [3:0]    fetch_ok;
   logic          rsp_valid;
   logic [31:0]   rsp_addr;
   logic [255:0]  rsp_data;
   logic [1:0]    rsp_mask;
   logic [1:0]    rsp_wid;
   logic          rsp_status;
   logic          flush_valid;
   logic [1:0]    flush_wid;
   logic          replay_valid;
   logic [1:0]    replay_wid;
   logic [31:0]   replay_pc;
   logic [3:0]    ib_valid;
   logic [3:0]    ib_ready;
   logic [127:0]  ib_inst;
   logic [127:0]  ib_pc;
   logic          ovf_err;
`ifdef IBUF_PERF_EN
   logic [31:0]   perf_hit;
   logic [31:0]   perf_miss;
`endif

   always #5 clk = ~clk;

   fetch_rsp_ibuffer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_fire_i     (req_fire),
      .req_wid_i      (req_wid),
      .fetch_ok_o     (fetch_ok),
      .rsp_valid_i    (rsp_valid),
      .rsp_addr_i     (rsp_addr),
      .rsp_data_i     (rsp_data),
      .rsp_mask_i     (rsp_mask),
      .rsp_wid_i      (rsp_wid),
      .rsp_status_i   (rsp_status),
      .flush_valid_i  (flush_valid),
      .flush_wid_i    (flush_wid),
      .replay_valid_o (replay_valid),
      .replay_wid_o   (replay_wid),
      .replay_pc_o    (replay_pc),
      .ib_valid_o     (ib_valid),
      .ib_ready_i     (ib_ready),
      .ib_inst_o      (ib_inst),
      .ib_pc_o        (ib_pc),
`ifdef IBUF_PERF_EN
      .perf_hit_o     (perf_hit),
      .perf_miss_o    (perf_miss),
`endif
      .ovf_err_o      (ovf_err)
   );

   typedef struct {
      logic        fire;  logic [1:0]  fwid;
      logic        rv;    logic        st;   logic [1:0] rwid;
      logic [31:0] addr;  logic [1:0]  mask;
      logic        fl;    logic [1:0]  flw;  logic [3:0] rdy;
      logic [3:0]  e_ok;  logic [3:0]  e_iv;
      logic        e_rv;  logic [1:0]  e_rw; logic [31:0] e_rpc;
      logic        e_ovf;
      logic [1:0]  hw;    logic [31:0] e_inst; logic [31:0] e_pc;
   } vec_t;

   vec_t vt[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic fire, input logic [1:0] fwid,
      input logic rv, input logic st, input logic [1:0] rwid, input logic [31:0] addr, input logic [1:0] mask,
      input logic fl, input logic [1:0] flw, input logic [3:0] rdy,
      input logic [3:0] e_ok, input logic [3:0] e_iv, input logic e_rv, input logic [1:0] e_rw,
      input logic [31:0] e_rpc, input logic e_ovf,
      input logic [1:0] hw, input logic [31:0] e_inst, input logic [31:0] e_pc);
      vec_t v;
      v.fire = fire; v.fwid = fwid; v.rv = rv; v.st = st; v.rwid = rwid; v.addr = addr; v.mask = mask;
      v.fl = fl; v.flw = flw; v.rdy = rdy; v.e_ok = e_ok; v.e_iv = e_iv; v.e_rv = e_rv; v.e_rw = e_rw;
      v.e_rpc = e_rpc; v.e_ovf = e_ovf; v.hw = hw; v.e_inst = e_inst; v.e_pc = e_pc;
      return v;
   endfunction

   task automatic idle_inputs();
      req_fire = 1'b0; req_wid = '0; rsp_valid = 1'b0; rsp_addr = '0; rsp_mask = '0;
      rsp_wid = '0; rsp_status = 1'b0; flush_valid = 1'b0; flush_wid = '0; ib_ready = '0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " fetch_ok"},     32'(fetch_ok),     32'hF);
      chk({tag, " ib_valid"},     32'(ib_valid),     32'h0);
      chk({tag, " replay_valid"}, 32'(replay_valid), 32'h0);
      chk({tag, " replay_wid"},   32'(replay_wid),   32'h0);
      chk({tag, " replay_pc"},    replay_pc,         32'h0);
      chk({tag, " ovf_err"},      32'(ovf_err),      32'h0);
   endtask

   initial begin
      // Block word k holds 8+k, so word 2 = 0xA, word 3 = 0xB, word 7 = 0xF
      for (int k = 0; k < 8; k++) rsp_data[k*32 +: 32] = 32'(8 + k);
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      //      fire fw  rv st rw  addr          mask   fl flw rdy      e_ok     e_iv     rv rw  rpc           ovf hw  inst    pc
      vt.push_back(mk(1, 1,  0, 0, 0, 32'h0,     2'b00, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 32'h0,    0, 0, 32'h0, 32'h0));     // 0
      vt.push_back(mk(1, 1,  0, 0, 0, 32'h0,     2'b00, 0, 0, 4'b0000, 4'b1101, 4'b0000, 0, 0, 32'h0,    0, 0, 32'h0, 32'h0));     // 1 reserved=4
      vt.push_back(mk(0, 0,  1, 0, 1, 32'h1008,  2'b11, 0, 0, 4'b0000, 4'b1101, 4'b0010, 0, 0, 32'h0,    0, 1, 32'hA, 32'h1008));  // 2 hit
      vt.push_back(mk(0, 0,  0, 0, 0, 32'h0,     2'b00, 0, 0, 4'b0010, 4'b1101, 4'b0010, 0, 0, 32'h0,    0, 1, 32'hB, 32'h100C));  // 3 pop
      vt.push_back(mk(0, 0,  0, 0, 0, 32'h0,     2'b00, 0, 0, 4'b0010, 4'b1111, 4'b0000, 0, 0, 32'h0,    0, 1, 32'h0, 32'h0));     // 4 pop
      vt.push_back(mk(0, 0,  1, 0, 1, 32'h101C,  2'b11, 0, 0, 4'b0000, 4'b1111, 4'b0010, 0, 0, 32'h0,    0, 1, 32'hF, 32'h101C));  // 5 edge of block
      vt.push_back(mk(1, 2,  0, 0, 0, 32'h0,     2'b00, 0, 0, 4'b0010, 4'b1111, 4'b0000, 0, 0, 32'h0,    0, 1, 32'h0, 32'h0));     // 6
      vt.push_back(mk(0, 0,  1, 1, 2, 32'h2040,  2'b11, 0, 0, 4'b0000, 4'b1111, 4'b0000, 1, 2, 32'h2040, 0, 2, 32'h0, 32'h0));     // 7 miss
      vt.push_back(mk(0, 0,  0, 0, 0, 32'h0,     2'b00, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 32'h0,    0, 2, 32'h0, 32'h0));     // 8 pulse ends
      vt.push_back(mk(0, 0,  1, 0, 0, 32'h0,     2'b11, 0, 0, 4'b0000, 4'b1111, 4'b0001, 0, 0, 32'h0,    0, 0, 32'h8, 32'h0));     // 9
      vt.push_back(mk(0, 0,  1, 0, 0, 32'h8,     2'b01, 0, 0, 4'b0000, 4'b1110, 4'b0001, 0, 0, 32'h0,    0, 0, 32'h8, 32'h0));     // 10 count0=3
      vt.push_back(mk(0, 0,  1, 0, 0, 32'h0,     2'b11, 1, 0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 32'h0,    0, 0, 32'h0, 32'h0));     // 11 flush+hit
      vt.push_back(mk(0, 0,  1, 0, 3, 32'h3000,  2'b11, 0, 0, 4'b0000, 4'b1111, 4'b1000, 0, 0, 32'h0,    0, 3, 32'h8, 32'h3000));  // 12
      vt.push_back(mk(0, 0,  1, 0, 3, 32'h3008,  2'b11, 0, 0, 4'b0000, 4'b0111, 4'b1000, 0, 0, 32'h0,    0, 3, 32'h8, 32'h3000));  // 13 full
      vt.push_back(mk(0, 0,  1, 0, 3, 32'h3010,  2'b11, 0, 0, 4'b0000, 4'b0111, 4'b1000, 0, 0, 32'h0,    1, 3, 32'h8, 32'h3000));  // 14 overflow
      vt.push_back(mk(0, 0,  0, 0, 0, 32'h0,     2'b00, 0, 0, 4'b1000, 4'b0111, 4'b1000, 0, 0, 32'h0,    1, 3, 32'h9, 32'h3004));  // 15 pop
      vt.push_back(mk(0, 0,  1, 0, 3, 32'h3010,  2'b11, 0, 0, 4'b1000, 4'b0111, 4'b1000, 0, 0, 32'h0,    1, 3, 32'hA, 32'h3008));  // 16 pop+push
      vt.push_back(mk(0, 0,  0, 0, 0, 32'h0,     2'b00, 0, 0, 4'b1000, 4'b0111, 4'b1000, 0, 0, 32'h0,    1, 3, 32'hB, 32'h300C));  // 17
      vt.push_back(mk(0, 0,  0, 0, 0, 32'h0,     2'b00, 0, 0, 4'b1000, 4'b1111, 4'b1000, 0, 0, 32'h0,    1, 3, 32'hC, 32'h3010));  // 18
      vt.push_back(mk(0, 0,  0, 0, 0, 32'h0,     2'b00, 0, 0, 4'b1000, 4'b1111, 4'b1000, 0, 0, 32'h0,    1, 3, 32'hD, 32'h3014));  // 19
      vt.push_back(mk(0, 0,  0, 0, 0, 32'h0,     2'b00, 0, 0, 4'b1000, 4'b1111, 4'b0000, 0, 0, 32'h0,    1, 3, 32'h0, 32'h0));     // 20 drained
      vt.push_back(mk(0, 0,  1, 1, 2, 32'h2080,  2'b11, 1, 2, 4'b0000, 4'b1111, 4'b0000, 0, 0, 32'h0,    1, 2, 32'h0, 32'h0));     // 21 flushed miss
      vt.push_back(mk(0, 0,  1, 0, 1, 32'h1000,  2'b10, 0, 0, 4'b0000, 4'b1111, 4'b0010, 0, 0, 32'h0,    1, 1, 32'h9, 32'h1004));  // 22 slot1 only
      vt.push_back(mk(0, 0,  0, 0, 0, 32'h0,     2'b00, 1, 2, 4'b0000, 4'b1111, 4'b0010, 0, 0, 32'h0,    1, 1, 32'h9, 32'h1004));  // 23 other-warp flush
      vt.push_back(mk(1, 1,  0, 0, 0, 32'h0,     2'b00, 0, 0, 4'b0000, 4'b1101, 4'b0010, 0, 0, 32'h0,    1, 1, 32'h9, 32'h1004));  // 24
      vt.push_back(mk(1, 1,  1, 0, 1, 32'h1010,  2'b00, 0, 0, 4'b0000, 4'b1101, 4'b0010, 0, 0, 32'h0,    1, 1, 32'h9, 32'h1004));  // 25 net credit 0

      for (int k = 0; k < vt.size(); k++) begin
         vec_t v;
         v = vt[k];
         req_fire = v.fire; req_wid = v.fwid; rsp_valid = v.rv; rsp_status = v.st;
         rsp_wid = v.rwid; rsp_addr = v.addr; rsp_mask = v.mask;
         flush_valid = v.fl; flush_wid = v.flw; ib_ready = v.rdy;
         @(posedge clk);
         #1;
         idle_inputs();
         chk($sformatf("v%0d fetch_ok", k),     32'(fetch_ok),     32'(v.e_ok));
         chk($sformatf("v%0d ib_valid", k),     32'(ib_valid),     32'(v.e_iv));
         chk($sformatf("v%0d replay_valid", k), 32'(replay_valid), 32'(v.e_rv));
         chk($sformatf("v%0d ovf_err", k),      32'(ovf_err),      32'(v.e_ovf));
         if (v.e_rv) begin
            chk($sformatf("v%0d replay_wid", k), 32'(replay_wid), 32'(v.e_rw));
            chk($sformatf("v%0d replay_pc", k),  replay_pc,       v.e_rpc);
         end
         if (v.e_iv[v.hw]) begin
            chk($sformatf("v%0d head_inst", k), ib_inst[v.hw*32 +: 32], v.e_inst);
            chk($sformatf("v%0d head_pc", k),   ib_pc[v.hw*32 +: 32],   v.e_pc);
         end
      end

`ifdef IBUF_PERF_EN
      chk("perf_hit",  perf_hit,  32'd10);
      chk("perf_miss", perf_miss, 32'd1);
`endif

      // Asynchronous reset mid-cycle: state clears without a clock edge
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // After reset: fresh FIFO takes a hit at idx 1 and drains in order
      rsp_valid = 1'b1; rsp_wid = 2'd2; rsp_addr = 32'h2004; rsp_mask = 2'b11;
      @(posedge clk);
      #1;
      idle_inputs();
      chk("post_reset ib_valid",  32'(ib_valid), 32'h4);
      chk("post_reset head_inst", ib_inst[64 +: 32], 32'h9);
      chk("post_reset head_pc",   ib_pc[64 +: 32],   32'h2004);
      ib_ready = 4'b0100;
      @(posedge clk);
      #1;
      chk("post_reset second_inst", ib_inst[64 +: 32], 32'hA);
      chk("post_reset second_pc",   ib_pc[64 +: 32],   32'h2008);
      @(posedge clk);
      #1;
      idle_inputs();
      chk("post_reset drained", 32'(ib_valid), 32'h0);
      chk("post_reset ovf_err", 32'(ovf_err),  32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
